// File: rtl/note_scheduler.sv
// note_scheduler: places note records into round-robin voice slots and times wait records in beats.
// All outputs are registered; advance pulses for one cycle once a wait has expired while playing.
module note_scheduler #(
  parameter int NUM_VOICES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    beat,
  input  logic                    load_count,
  input  logic                    type_signal,
  input  logic [5:0]              note,
  input  logic [5:0]              duration,
  input  logic [2:0]              meta,
  input  logic                    song_done,
  output logic                    advance,
  output logic [6*NUM_VOICES-1:0] voice_notes,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   voice_new,
  output logic                    finished
);
  typedef enum logic [1:0] {IDLE, WAIT, FIRE, DONE} state_t;

  state_t                state_q;
  logic [5:0]            wait_cnt_q;
  logic                  advance_q;
  logic                  finished_q;
  logic [1:0]            ptr_q, ptr_d, slot;
  logic                  chord_q, chord_d;
  logic [5:0]            notes_q [NUM_VOICES];
  logic [5:0]            notes_d [NUM_VOICES];
  logic [5:0]            sus_q [NUM_VOICES];
  logic [5:0]            sus_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] new_q, new_d;
  logic                  halted, note_ld, wait_ld, tick;
  logic                  unused_meta;

  assign unused_meta = ^meta;
  assign halted      = song_done | (state_q == DONE);
  assign note_ld     = load_count & ~type_signal & ~halted;
  assign wait_ld     = load_count & type_signal & ~halted;
  assign tick        = beat & play;

  // Slot writes are applied after sustain decay so a same-cycle load always wins.
  always_comb begin
    ptr_d    = ptr_q;
    chord_d  = chord_q;
    active_d = active_q;
    new_d    = '0;
    slot     = chord_q ? 2'd0 : ptr_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      notes_d[i] = notes_q[i];
      sus_d[i]   = sus_q[i];
      if (tick && active_q[i] && (sus_q[i] != 6'd0)) begin
        sus_d[i] = sus_q[i] - 6'd1;
        if (sus_q[i] == 6'd1) active_d[i] = 1'b0;
      end
    end
    if (wait_ld) chord_d = 1'b1;
    if (note_ld) begin
      chord_d = 1'b0;
      if (chord_q) active_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if ((int'(slot) == i) && (note != 6'd0)) begin
          notes_d[i]  = note;
          sus_d[i]    = duration;
          active_d[i] = 1'b1;
          new_d[i]    = 1'b1;
        end
      end
      ptr_d = (int'(slot) == NUM_VOICES - 1) ? 2'd0 : slot + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      chord_q  <= 1'b1;
      active_q <= '0;
      new_q    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes_q[i] <= '0;
        sus_q[i]   <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      chord_q  <= chord_d;
      active_q <= active_d;
      new_q    <= new_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes_q[i] <= notes_d[i];
        sus_q[i]   <= sus_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      advance_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      advance_q <= 1'b0;
      if (song_done) begin
        state_q    <= DONE;
        finished_q <= 1'b1;
      end else if (wait_ld) begin
        state_q    <= WAIT;
        wait_cnt_q <= duration;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          WAIT: begin
            if (play) begin
              if (wait_cnt_q == 6'd0) begin
                state_q   <= FIRE;
                advance_q <= 1'b1;
              end else if (beat) begin
                wait_cnt_q <= wait_cnt_q - 6'd1;
              end
            end
          end
          FIRE: if (play) state_q <= IDLE;
          DONE: state_q <= DONE;
        endcase
      end
    end
  end

  assign advance      = advance_q;
  assign finished     = finished_q;
  assign voice_active = active_q;
  assign voice_new    = new_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_notes
    assign voice_notes[6*g +: 6] = notes_q[g];
  end
endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed song fragments plus randomized records against a behavioural model.
module tb_note_scheduler;
  localparam int NV = 3;

  logic            clk = 1'b0;
  logic            reset, play, beat, load_count, type_signal, song_done;
  logic [5:0]      note, duration;
  logic [2:0]      meta;
  logic            advance, finished;
  logic [6*NV-1:0] voice_notes;
  logic [NV-1:0]   voice_active, voice_new;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int adv_cnt = 0;
  int adv_edge = -1;
  int beat_per = 0;
  int beat_edges[$];

  // Behavioural model: per-slot note/sustain, chord flag, and beats left on the pending wait.
  int m_note[NV];
  int m_sus[NV];
  bit m_act[NV];
  bit m_new[NV];
  int m_ptr, m_wleft;
  bit m_chord, m_wait, m_done, m_adv;

  note_scheduler #(.NUM_VOICES(NV)) dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .load_count(load_count),
    .type_signal(type_signal), .note(note), .duration(duration), .meta(meta),
    .song_done(song_done), .advance(advance), .voice_notes(voice_notes),
    .voice_active(voice_active), .voice_new(voice_new), .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_sus[i] = 0; m_act[i] = 0; m_new[i] = 0;
    end
    m_ptr = 0; m_wleft = 0; m_chord = 1; m_wait = 0; m_done = 0; m_adv = 0;
  endtask

  task automatic m_edge();
    bit tick = beat && play;
    bit halt = m_done || song_done;
    bit nld  = load_count && !type_signal && !halt;
    bit wld  = load_count && type_signal && !halt;
    for (int i = 0; i < NV; i++) begin
      m_new[i] = 0;
      if (tick && m_act[i] && m_sus[i] > 0) begin
        m_sus[i]--;
        if (m_sus[i] == 0) m_act[i] = 0;
      end
    end
    if (nld) begin
      if (m_chord) begin
        for (int i = 0; i < NV; i++) m_act[i] = 0;
        m_ptr = 0;
        m_chord = 0;
      end
      if (note != 0) begin
        m_note[m_ptr] = note; m_sus[m_ptr] = duration; m_act[m_ptr] = 1; m_new[m_ptr] = 1;
      end
      m_ptr = (m_ptr + 1) % NV;
    end
    m_adv = 0;
    if (song_done) begin
      m_done = 1; m_wait = 0;
    end else if (wld) begin
      m_wait = 1; m_wleft = duration; m_chord = 1;
    end else if (m_wait && play) begin
      if (m_wleft == 0) begin m_adv = 1; m_wait = 0; end
      else if (beat) m_wleft--;
    end
  endtask

  function automatic logic [31:0] m_notes_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++) v[6*i +: 6] = m_note[i][5:0];
    return v;
  endfunction

  function automatic logic [31:0] m_bits(input bit sel_new);
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = sel_new ? m_new[i] : m_act[i];
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    edge_no++;
    m_edge();
    if (beat) beat_edges.push_back(edge_no);
    #1;
    if (advance) begin adv_cnt++; adv_edge = edge_no; end
    check_val("advance", advance, m_adv);
    check_val("voice_notes", voice_notes, m_notes_vec());
    check_val("voice_active", voice_active, m_bits(0));
    check_val("voice_new", voice_new, m_bits(1));
    check_val("finished", finished, m_done);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      beat = (beat_per > 0) && ((edge_no + 1) % beat_per == 0);
      cycle();
    end
    beat = 1'b0;
  endtask

  task automatic rec(input bit t, input int n, input int d);
    load_count = 1'b1; type_signal = t; note = 6'(n); duration = 6'(d); beat = 1'b0;
    cycle();
    load_count = 1'b0; type_signal = 1'b0; note = '0; duration = '0;
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    #2;
    m_reset();
    check_val({tag, "_adv"}, advance, 0);
    check_val({tag, "_notes"}, voice_notes, 0);
    check_val({tag, "_active"}, voice_active, 0);
    check_val({tag, "_new"}, voice_new, 0);
    check_val({tag, "_fin"}, finished, 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; beat = 1'b0; load_count = 1'b0; type_signal = 1'b0;
    note = '0; duration = '0; meta = '0; song_done = 1'b0;
    m_reset();
    #12;
    check_val("rst_notes", voice_notes, 0);
    check_val("rst_active", voice_active, 0);
    check_val("rst_adv", advance, 0);
    reset = 1'b0;
    play = 1'b1;

    // Two-note chord then a 3-beat wait.
    rec(0, 10, 0);
    check_val("A_new0", voice_new, 3'b001);
    rec(0, 14, 0);
    check_val("A_new1", voice_new, 3'b010);
    rec(1, 0, 3);
    beat_edges.delete(); adv_cnt = 0; beat_per = 4;
    run(20);
    check_val("A_notes", voice_notes, {6'd0, 6'd14, 6'd10});
    check_val("A_adv_cnt", adv_cnt, 1);
    check_val("A_adv_edge", adv_edge, beat_edges[2] + 1);

    // New chord clears all slots; sustain of 2 beats.
    rec(0, 20, 2);
    check_val("B_active", voice_active, 3'b001);
    check_val("B_notes", voice_notes, {6'd0, 6'd14, 6'd20});
    run(12);
    check_val("B_decayed", voice_active, 3'b000);

    // Four-note chord wraps onto slot 0; a rest skips a slot.
    beat_per = 0;
    rec(1, 0, 0); run(4);
    rec(0, 5, 0); check_val("C_new5", voice_new, 3'b001);
    rec(0, 6, 0); check_val("C_new6", voice_new, 3'b010);
    rec(0, 7, 0); check_val("C_new7", voice_new, 3'b100);
    rec(0, 8, 0); check_val("C_new8", voice_new, 3'b001);
    check_val("C_notes", voice_notes, {6'd7, 6'd6, 6'd8});
    rec(1, 0, 0); run(4);
    rec(0, 9, 0);  check_val("C_new9", voice_new, 3'b001);
    rec(0, 0, 0);  check_val("C_rest", voice_new, 3'b000);
    rec(0, 11, 0); check_val("C_new11", voice_new, 3'b100);
    check_val("C_active", voice_active, 3'b101);
    check_val("C_notes2", voice_notes, {6'd11, 6'd6, 6'd9});

    // Pause during a wait freezes the counter.
    beat_per = 4;
    rec(1, 0, 2);
    play = 1'b0; adv_cnt = 0;
    run(40);
    check_val("D_paused_adv", adv_cnt, 0);
    play = 1'b1; beat_edges.delete();
    run(20);
    check_val("D_adv_cnt", adv_cnt, 1);
    check_val("D_adv_edge", adv_edge, beat_edges[1] + 1);

    // Zero-length wait and a beat coincident with a load.
    beat_per = 0;
    rec(1, 0, 0);
    run(1);
    check_val("E_zero_lat", advance, 1);
    load_count = 1'b1; type_signal = 1'b1; duration = 6'd1; beat = 1'b1;
    cycle();
    load_count = 1'b0; type_signal = 1'b0; duration = '0; beat = 1'b0;
    adv_cnt = 0;
    run(6);
    check_val("E_no_early", adv_cnt, 0);
    beat = 1'b1; cycle(); beat = 1'b0;
    run(4);
    check_val("E_adv_cnt", adv_cnt, 1);

    // End of song during a wait.
    rec(0, 33, 3);
    rec(1, 0, 5);
    beat_per = 4;
    run(6);
    song_done = 1'b1; cycle(); song_done = 1'b0;
    check_val("F_finished", finished, 1);
    adv_cnt = 0;
    run(40);
    check_val("F_no_adv", adv_cnt, 0);
    check_val("F_decayed", voice_active, 3'b000);
    rec(0, 30, 3);
    check_val("F_ignored", voice_new, 3'b000);
    rec(1, 0, 0);
    run(5);
    check_val("F_no_adv2", adv_cnt, 0);
    async_reset_check("F_rst");

    // Reset between a zero-length wait load and its advance.
    beat_per = 0;
    rec(1, 0, 0);
    async_reset_check("G_rst");
    adv_cnt = 0;
    run(5);
    check_val("G_no_adv", adv_cnt, 0);

    // Randomized records; song_done late in the run.
    for (int k = 0; k < 3000; k++) begin
      play        = ($urandom_range(0, 9) != 0);
      beat        = !beat && ($urandom_range(0, 2) == 0);
      load_count  = play && ($urandom_range(0, 4) == 0);
      type_signal = ($urandom_range(0, 2) == 0);
      note        = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      duration    = 6'($urandom_range(0, 4));
      meta        = 3'($urandom);
      song_done   = (k == 2600);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_scheduler.md
# note_scheduler

Consumer side of the song reader's record stream. Takes the note and wait records strobed out by the song reader and assigns note records to voice slots for the synth. It times each wait record in beat ticks and returns the one-cycle `advance` that releases the reader from its wait. It also latches end-of-song.

## Interface
Parameters:
- NUM_VOICES, 3, number of simultaneous voice slots (2..4).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; one clock domain.
- play  input  1  run enable, shared with the song reader; 0 = pause.
- beat  input  1  one-cycle tempo tick, at most one per 2 clk.
- load_count  input  1  record strobe from the reader; one cycle per record.
- type_signal  input  1  0 = note record, 1 = wait record; valid when load_count=1.
- note  input  6  note number; 0 = rest.
- duration  input  6  beats: note sustain (note record) or wait length (wait record).
- meta  input  3  ignored by this block.
- song_done  input  1  reader end-of-song flag.
- advance  output  1  one-cycle pulse releasing the reader from its wait.
- voice_notes  output  6*NUM_VOICES  per-slot note number; slot i is at bits [6i+5:6i].
- voice_active  output  NUM_VOICES  slot currently sounding.
- voice_new  output  NUM_VOICES  one-cycle pulse when a slot is (re)loaded.
- finished  output  1  sticky end-of-song.

## Operation
- FSM states are IDLE, WAIT, FIRE and DONE. Reset puts the FSM in IDLE, sets every output and counter to 0 and sets the voice pointer to 0.
- The FSM changes state only while play=1, except that the DONE transition described below is unconditional. Record capture (load_count) is never gated by play.

Note record (load_count=1, type_signal=0):
- If the previous record was a wait record, or this is the first record since reset, this note starts a new chord: all slots clear voice_active in the same cycle and the pointer goes to 0 before the slot is written.
- note != 0: slot[ptr] takes the note number, voice_active[ptr]=1, voice_new[ptr] pulses and the sustain counter is loaded with duration.
- Sustain duration 0 means the slot holds until the next chord clear.
- note == 0 (rest): no slot is written and nothing pulses, but ptr still increments.
- ptr increments mod NUM_VOICES. An extra note in a chord overwrites slot 0 and continues round-robin.

Wait record (load_count=1, type_signal=1):
- The wait counter is loaded with duration and the FSM goes to WAIT. This happens from any state except DONE.
- A wait record arriving in WAIT restarts the counter.

WAIT state:
- Each beat with play=1 decrements the wait counter.
- When the counter reaches 0, or if duration was 0 at load, the FSM goes to FIRE on the next clk.

FIRE state:
- advance=1 for exactly one cycle, then the FSM returns to IDLE.
- If play drops while in WAIT, the counter freezes. advance is never issued while play=0; FIRE is entered only when play=1.

Sustain counters:
- Each active slot with a nonzero sustain value decrements on every beat while play=1.
- When a slot's counter reaches 0 it clears voice_active.
- voice_notes keeps its last value and is cleared only by reset.

End of song:
- song_done=1 sets finished and forces DONE from any state.
- In DONE, advance stays 0, load_count is ignored and voices decay normally.
- Only reset leaves DONE.

Width and arithmetic:
- Counters are 6-bit and never decrement below 0.
- ptr is 2 bits wide.

## Timing
- All outputs are registered.
- A load sampled at edge N drives voice_new, voice_notes and voice_active from edge N through edge N+1.
- For a wait of duration D: the counter is loaded at edge N, the D-th counted beat after that takes the counter to 0, and advance is high during the cycle after the next edge. Zero-duration latency is 2 clk from the load.
- If load_count and beat arrive in the same cycle, the load wins: that beat is not counted by any counter loaded in that cycle. Other active counters still count it.
- If a chord clear and a sustain expiry happen in the same cycle, the clear wins and the newly written slot is active.
- Asynchronous reset mid-wait clears the FSM immediately, so no advance is produced.

## Test plan
- Record sequence note 10 dur 0, note 14 dur 0, wait dur 3, with beats every 4 clk:
  - voice_new pulses 001 then 010.
  - voice_notes = {0,14,10}.
  - Exactly one advance, in the cycle after the clock edge that samples the 3rd beat.
- Next chord after that wait, note 20 dur 2:
  - All slots clear in the load cycle and slot0=20 is active.
  - voice_active[0] drops after 2 beats.
- Chord of 4 notes (5, 6, 7, 8):
  - Slot0 ends as 8, voice_new sequence is 001, 010, 100, 001.
  - A rest note (0) mid-chord skips a slot without pulsing it.
- Wait dur 2 with play=0 for 10 beats, then play=1:
  - No advance while paused.
  - advance comes after 2 further beats.
- Wait dur 0 produces advance 2 clk after load. A beat coincident with a load of dur 1 is not counted, so advance comes after the next beat.
- song_done asserted during WAIT:
  - finished=1 and advance never pulses.
  - Later records are ignored.
  - Asynchronous reset returns all outputs to 0 with no clock.
